postbox_tx_fifo: RTL and testbench



---
 rtl/postbox_tx_fifo.sv | 125 ++++++++++++
 tb/tb_postbox_tx_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/postbox_tx_fifo.sv
// Transmit byte FIFO feeding the POST-box decoder input path; pops one entry per tx_done rising edge.
// Optional sticky overflow status (ovf / ovf_clr) is enabled by defining TXFIFO_OVF_STATUS_EN.
module postbox_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              refclk,
   input  logic              reset,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   output logic              full,
   output logic [7:0]        txin,
   output logic              tx_pending,
   input  logic              tx_done,
   output logic [ADDR_W:0]   count
`ifdef TXFIFO_OVF_STATUS_EN
   ,
   output logic              ovf,
   input  logic              ovf_clr
`endif
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wptr_reg;
   logic [ADDR_W-1:0] rptr_reg;
   logic [ADDR_W-1:0] rptr_inc;
   logic [ADDR_W:0]   count_reg;
   logic [7:0]        txin_reg;
   logic [7:0]        head_next;
   logic              s1_reg;
   logic              s2_reg;
   logic              s3_reg;
   logic [2:0]        live_reg;
   logic              pop;
   logic              pop_ok;
   logic              wr_ok;
   logic              is_full;
   logic              is_empty;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == DEPTH_CNT);
   // live_reg keeps s3 from being trusted until it has sampled real history after
   // reset, so a tx_done already high at release never reads as a fresh edge.
   assign pop      = s2_reg & ~s3_reg & live_reg[2];
   assign pop_ok   = pop & ~is_empty;
   assign wr_ok    = wr_en & (~is_full | pop_ok);
   assign rptr_inc = rptr_reg + 1'b1;

   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         s1_reg   <= 1'b0;
         s2_reg   <= 1'b0;
         s3_reg   <= 1'b0;
         live_reg <= 3'b000;
      end else begin
         s1_reg   <= tx_done;
         s2_reg   <= s1_reg;
         s3_reg   <= s2_reg;
         live_reg <= {live_reg[1:0], 1'b1};
      end
   end

   // Head byte is registered so txin only moves on a pop or a write into an empty queue.
   always_comb begin
      head_next = txin_reg;
      if (pop_ok) begin
         if (count_reg == ONE_CNT)
            head_next = wr_ok ? wr_data : 8'h00;
         else
            head_next = mem[rptr_inc];
      end else if (wr_ok && is_empty) begin
         head_next = wr_data;
      end
   end

   always_ff @(posedge refclk) begin
      if (wr_ok)
         mem[wptr_reg] <= wr_data;
   end

   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
         txin_reg  <= 8'h00;
      end else begin
         if (wr_ok)
            wptr_reg <= wptr_reg + 1'b1;
         if (pop_ok)
            rptr_reg <= rptr_inc;
         unique case ({wr_ok, pop_ok})
            2'b10:   count_reg <= count_reg + ONE_CNT;
            2'b01:   count_reg <= count_reg - ONE_CNT;
            default: count_reg <= count_reg;
         endcase
         txin_reg <= head_next;
      end
   end

`ifdef TXFIFO_OVF_STATUS_EN
   logic ovf_reg;

   // Set wins over clear so a drop coinciding with ovf_clr is not lost.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset)
         ovf_reg <= 1'b0;
      else if (wr_en && is_full && !pop_ok)
         ovf_reg <= 1'b1;
      else if (ovf_clr)
         ovf_reg <= 1'b0;
   end

   assign ovf = ovf_reg;
`endif

   assign count      = count_reg;
   assign full       = is_full;
   assign tx_pending = ~is_empty;
   assign txin       = txin_reg;

endmodule

// File: tb/tb_postbox_tx_fifo.sv
// Bench for postbox_tx_fifo: directed plan plus random traffic, checked by a queue-based scoreboard.
`timescale 1ns/1ps
module tb_postbox_tx_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              refclk;
   logic              reset;
   logic [7:0]        wr_data;
   logic              wr_en;
   logic              full;
   logic [7:0]        txin;
   logic              tx_pending;
   logic              tx_done;
   logic [ADDR_W:0]   count;
`ifdef TXFIFO_OVF_STATUS_EN
   logic              ovf;
   logic              ovf_clr;
`endif

   int checks   = 0;
   int failures = 0;
   int mon_cnt  = 0;

   postbox_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .refclk     (refclk),
      .reset      (reset),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .full       (full),
      .txin       (txin),
      .tx_pending (tx_pending),
      .tx_done    (tx_done),
      .count      (count)
`ifdef TXFIFO_OVF_STATUS_EN
      ,
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
`endif
   );

   initial refclk = 1'b0;
   always #250 refclk = ~refclk;

   typedef struct {
      logic [7:0] txin;
      logic       pend;
      logic       full;
      logic [31:0] count;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      tick(1);
      wr_en   = 1'b0;
   endtask

   task automatic pulse(input int hi, input int lo);
      tx_done = 1'b1;
      tick(hi);
      tx_done = 1'b0;
      tick(lo);
   endtask

   // Reference model: a byte queue plus a list of cycles at which a pop falls due.
   initial begin : model
      logic [7:0] q[$];
      int         due_q[$];
      int         cyc;
      bit         started;
      logic       prev_td;
      bit         due_now;
      bit         pop_eff;
      bit         wr_ok;
      logic       m_ovf;
      exp_t       e;
      cyc     = 0;
      started = 0;
      prev_td = 1'b0;
      m_ovf   = 1'b0;
      forever begin
         @(posedge refclk);
         cyc++;
         if (reset) begin
            q.delete();
            due_q.delete();
            started = 0;
            m_ovf   = 1'b0;
         end else begin
            due_now = (due_q.size() > 0) && (due_q[0] == cyc);
            if (due_now)
               void'(due_q.pop_front());
            // A rise first sampled at this edge is applied two edges later.
            if (started && !prev_td && tx_done)
               due_q.push_back(cyc + 2);
            prev_td = tx_done;
            started = 1;
            pop_eff = due_now && (q.size() > 0);
            wr_ok   = wr_en && ((q.size() < DEPTH) || pop_eff);
`ifdef TXFIFO_OVF_STATUS_EN
            if (wr_en && !wr_ok)
               m_ovf = 1'b1;
            else if (ovf_clr)
               m_ovf = 1'b0;
`endif
            if (pop_eff)
               $display("POP  data=%h left=%0d", q.pop_front(), q.size());
            if (wr_ok) begin
               q.push_back(wr_data);
               $display("WR   data=%h count=%0d", wr_data, q.size());
            end else if (wr_en) begin
               $display("DROP data=%h count=%0d", wr_data, q.size());
            end
         end
         e.count = q.size();
         e.txin  = (q.size() > 0) ? q[0] : 8'h00;
         e.pend  = (q.size() > 0);
         e.full  = (q.size() == DEPTH);
         e.ovf   = m_ovf;
         exp_q.push_back(e);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge refclk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (reset) begin
               e.count = 0;
               e.txin  = 8'h00;
               e.pend  = 1'b0;
               e.full  = 1'b0;
               e.ovf   = 1'b0;
            end
            mon_cnt++;
            check("sb_count", 32'(count), e.count);
            check("sb_txin", 32'(txin), 32'(e.txin));
            check("sb_pending", 32'(tx_pending), 32'(e.pend));
            check("sb_full", 32'(full), 32'(e.full));
`ifdef TXFIFO_OVF_STATUS_EN
            check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int td_left;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_done = 1'b0;
`ifdef TXFIFO_OVF_STATUS_EN
      ovf_clr = 1'b0;
`endif
      tick(3);
      check("reset_count", 32'(count), 0);
      check("reset_pending", 32'(tx_pending), 0);
      check("reset_txin", 32'(txin), 0);
      reset = 1'b0;
      tick(2);

      // 1: two writes, show-ahead head
      write_byte(8'hA5);
      write_byte(8'h3C);
      check("t1_txin", 32'(txin), 32'hA5);
      check("t1_pending", 32'(tx_pending), 1);
      check("t1_count", 32'(count), 2);

      // 2: long pulse pops exactly once, on the third edge after the rise
      tx_done = 1'b1;
      tick(2);
      check("t2_no_early_pop", 32'(count), 2);
      tick(1);
      check("t2_count", 32'(count), 1);
      check("t2_txin", 32'(txin), 32'h3C);
      tick(1);
      tx_done = 1'b0;
      tick(4);
      check("t2_single_pop", 32'(count), 1);
      pulse(4, 4);
      check("t2_empty_count", 32'(count), 0);
      check("t2_empty_pending", 32'(tx_pending), 0);
      check("t2_empty_txin", 32'(txin), 0);

      // 3: fill, overflow drop, drain in order across pointer wrap
      for (int i = 0; i < DEPTH; i++)
         write_byte(8'(i));
      check("t3_full", 32'(full), 1);
      check("t3_count", 32'(count), DEPTH);
      write_byte(8'hFF);
      check("t3_drop_count", 32'(count), DEPTH);
`ifdef TXFIFO_OVF_STATUS_EN
      check("t3_ovf", 32'(ovf), 1);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         pulse(2, 2);
         check("t3_drain_count", 32'(count), 32'(DEPTH - 1 - i));
         check("t3_drain_txin", 32'(txin), (i == DEPTH - 1) ? 32'h00 : 32'(i + 1));
      end

      // 4: write while full coinciding with the synchronised pop
`ifdef TXFIFO_OVF_STATUS_EN
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("t4_ovf_cleared", 32'(ovf), 0);
`endif
      for (int i = 0; i < DEPTH; i++)
         write_byte(8'(8'h10 + i));
      tx_done = 1'b1;
      tick(2);
      wr_en   = 1'b1;
      wr_data = 8'h77;
      tick(1);
      wr_en   = 1'b0;
      check("t4_count", 32'(count), DEPTH);
      check("t4_txin", 32'(txin), 32'h11);
`ifdef TXFIFO_OVF_STATUS_EN
      check("t4_ovf", 32'(ovf), 0);
`endif
      tick(1);
      tx_done = 1'b0;
      tick(2);
      for (int i = 0; i < DEPTH - 1; i++)
         pulse(2, 2);
      check("t4_last_entry", 32'(txin), 32'h77);
      pulse(2, 2);
      check("t4_drained", 32'(count), 0);

      // 5: pop while empty is ignored
      pulse(3, 3);
      write_byte(8'h42);
      check("t5_count", 32'(count), 1);
      check("t5_txin", 32'(txin), 32'h42);

      // 6: reset with tx_done high; no pop until a fresh rise
      for (int i = 1; i <= 4; i++)
         write_byte(8'(i));
      check("t6_pre_count", 32'(count), 5);
      tx_done = 1'b1;
      tick(1);
      reset = 1'b1;
      tick(2);
      check("t6_reset_count", 32'(count), 0);
      check("t6_reset_txin", 32'(txin), 0);
      reset = 1'b0;
      write_byte(8'h55);
      write_byte(8'h66);
      tick(4);
      check("t6_no_pop_count", 32'(count), 2);
      check("t6_no_pop_txin", 32'(txin), 32'h55);
      tx_done = 1'b0;
      tick(3);
      tx_done = 1'b1;
      tick(3);
      check("t6_fresh_pop_count", 32'(count), 1);
      check("t6_fresh_pop_txin", 32'(txin), 32'h66);
      tick(1);
      tx_done = 1'b0;
      tick(3);

      // Random traffic, including one mid-run reset
      td_left = 3;
      for (int i = 0; i < 500; i++) begin
         wr_en   = ($urandom_range(0, 99) < 45);
         wr_data = 8'($urandom);
`ifdef TXFIFO_OVF_STATUS_EN
         ovf_clr = ($urandom_range(0, 39) == 0);
`endif
         reset   = (i >= 250 && i < 252);
         td_left--;
         if (td_left == 0) begin
            tx_done = ~tx_done;
            td_left = $urandom_range(2, 6);
         end
         tick(1);
      end
      wr_en   = 1'b0;
      reset   = 1'b0;
      tx_done = 1'b0;
`ifdef TXFIFO_OVF_STATUS_EN
      ovf_clr = 1'b0;
`endif
      tick(8);
      check("monitor_active", 32'(mon_cnt > 600), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
